// File: rtl/uart_cmd_parser.sv
// ASCII hex command-line parser between a UART's RX/TX FIFOs and a byte-wide register bus.
// "WAADD\r" writes a register and replies "K\r\n"; "RAA\r" reads one and replies "HH\r\n"; a bad line replies "E\r\n".
module uart_cmd_parser #(
  parameter logic [7:0] ACK_CHAR = 8'h4B,
  parameter logic [7:0] ERR_CHAR = 8'h45
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_data_out,
  output logic       rx_fifo_read_en,
  input  logic       tx_fifo_full,
  output logic [7:0] tx_fifo_data_in,
  output logic       tx_fifo_write_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] ADDR_HI = 4'd1;
  localparam logic [3:0] ADDR_LO = 4'd2;
  localparam logic [3:0] DATA_HI = 4'd3;
  localparam logic [3:0] DATA_LO = 4'd4;
  localparam logic [3:0] WAIT_CR = 4'd5;
  localparam logic [3:0] EXEC_WR = 4'd6;
  localparam logic [3:0] EXEC_RD = 4'd7;
  localparam logic [3:0] RD_WAIT = 4'd8;
  localparam logic [3:0] RESP    = 4'd9;
  localparam logic [3:0] DISCARD = 4'd10;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Returns {valid, nibble} for an ASCII hex digit in either case.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  logic [3:0] state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_vld_q;
  logic [7:0] addr_acc_q, addr_acc_d;
  logic [7:0] data_acc_q, data_acc_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wr_data_q, reg_wr_data_d;
  logic [7:0] resp_q [4];
  logic [7:0] resp_d [4];
  logic [2:0] resp_len_q, resp_len_d;
  logic [1:0] resp_idx_q, resp_idx_d;
  logic       wants_byte, is_cr, queue_err;
  logic [4:0] nib;

  // A popped byte sits in byte_q for one cycle while it is decoded; that cycle
  // is also the gap that lets the RX FIFO flags catch up before the next pop.
  assign wants_byte = (state_q == IDLE) || (state_q == ADDR_HI) || (state_q == ADDR_LO) ||
                      (state_q == DATA_HI) || (state_q == DATA_LO) || (state_q == WAIT_CR) ||
                      (state_q == DISCARD);
  assign rx_fifo_read_en  = wants_byte && !rx_fifo_empty && !byte_vld_q;
  assign byte_d           = rx_fifo_read_en ? rx_fifo_data_out : byte_q;
  assign is_cr            = (byte_q == CR);
  assign nib              = hex_nib(byte_q);

  assign tx_fifo_write_en = (state_q == RESP) && !tx_fifo_full;
  assign tx_fifo_data_in  = (state_q == RESP) ? resp_q[resp_idx_q] : 8'h00;
  assign reg_wr_en        = (state_q == EXEC_WR);
  assign reg_rd_en        = (state_q == EXEC_RD);
  assign reg_addr         = reg_addr_q;
  assign reg_wr_data      = reg_wr_data_q;
  assign busy             = (state_q != IDLE);
  assign state_dbg        = state_q;

  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    addr_acc_d    = addr_acc_q;
    data_acc_d    = data_acc_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    resp_d        = resp_q;
    resp_len_d    = resp_len_q;
    resp_idx_d    = resp_idx_q;
    queue_err     = 1'b0;
    case (state_q)
      IDLE: if (byte_vld_q && !is_cr && byte_q != LF) begin
        if (byte_q == 8'h57 || byte_q == 8'h77 || byte_q == 8'h52 || byte_q == 8'h72) begin
          is_wr_d    = (byte_q == 8'h57 || byte_q == 8'h77);
          addr_acc_d = 8'h00;
          data_acc_d = 8'h00;
          state_d    = ADDR_HI;
        end else begin
          state_d = DISCARD;
        end
      end
      ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: if (byte_vld_q) begin
        if (nib[4]) begin
          case (state_q)
            ADDR_HI: begin addr_acc_d[7:4] = nib[3:0]; state_d = ADDR_LO; end
            ADDR_LO: begin addr_acc_d[3:0] = nib[3:0]; state_d = is_wr_q ? DATA_HI : WAIT_CR; end
            DATA_HI: begin data_acc_d[7:4] = nib[3:0]; state_d = DATA_LO; end
            default: begin data_acc_d[3:0] = nib[3:0]; state_d = WAIT_CR; end
          endcase
        end else if (is_cr) begin
          queue_err = 1'b1;
        end else begin
          state_d = DISCARD;
        end
      end
      WAIT_CR: if (byte_vld_q) begin
        if (is_cr) begin
          reg_addr_d = addr_acc_q;
          if (is_wr_q) reg_wr_data_d = data_acc_q;
          state_d = is_wr_q ? EXEC_WR : EXEC_RD;
        end else begin
          state_d = DISCARD;
        end
      end
      DISCARD: if (byte_vld_q && is_cr) queue_err = 1'b1;
      EXEC_WR: begin
        resp_d[0]  = ACK_CHAR;
        resp_d[1]  = CR;
        resp_d[2]  = LF;
        resp_len_d = 3'd3;
        resp_idx_d = 2'd0;
        state_d    = RESP;
      end
      EXEC_RD: state_d = RD_WAIT;
      RD_WAIT: begin
        resp_d[0]  = hex_char(reg_rd_data[7:4]);
        resp_d[1]  = hex_char(reg_rd_data[3:0]);
        resp_d[2]  = CR;
        resp_d[3]  = LF;
        resp_len_d = 3'd4;
        resp_idx_d = 2'd0;
        state_d    = RESP;
      end
      RESP: if (!tx_fifo_full) begin
        if ({1'b0, resp_idx_q} == resp_len_q - 3'd1) begin
          resp_idx_d = 2'd0;
          state_d    = IDLE;
        end else begin
          resp_idx_d = resp_idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (queue_err) begin
      resp_d[0]  = ERR_CHAR;
      resp_d[1]  = CR;
      resp_d[2]  = LF;
      resp_len_d = 3'd3;
      resp_idx_d = 2'd0;
      state_d    = RESP;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      is_wr_q       <= 1'b0;
      byte_q        <= 8'h00;
      byte_vld_q    <= 1'b0;
      addr_acc_q    <= 8'h00;
      data_acc_q    <= 8'h00;
      reg_addr_q    <= 8'h00;
      reg_wr_data_q <= 8'h00;
      resp_q        <= '{default: 8'h00};
      resp_len_q    <= 3'd0;
      resp_idx_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      is_wr_q       <= is_wr_d;
      byte_q        <= byte_d;
      byte_vld_q    <= rx_fifo_read_en;
      addr_acc_q    <= addr_acc_d;
      data_acc_q    <= data_acc_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      resp_q        <= resp_d;
      resp_len_q    <= resp_len_d;
      resp_idx_q    <= resp_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: FIFO and register-bus models around the DUT, a line-level
// reference model feeding an expected-reply queue, directed scenarios and random lines.
module tb_uart_cmd_parser;
  typedef logic [7:0] bq_t[$];

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_fifo_empty = 1'b1;
  logic [7:0] rx_fifo_data_out = 8'h00;
  logic       rx_fifo_read_en;
  logic       tx_fifo_full = 1'b0;
  logic [7:0] tx_fifo_data_in;
  logic       tx_fifo_write_en;
  logic [7:0] reg_addr, reg_wr_data;
  logic       reg_wr_en, reg_rd_en;
  logic [7:0] reg_rd_data;
  logic       busy;
  logic [3:0] state_dbg;

  uart_cmd_parser dut (
    .clock(clock), .reset_n(reset_n),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data_out(rx_fifo_data_out), .rx_fifo_read_en(rx_fifo_read_en),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_data_in(tx_fifo_data_in), .tx_fifo_write_en(tx_fifo_write_en),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- environment models ----------------
  logic [7:0] rx_src[$];
  int         rx_rd_ptr = 0;
  logic [7:0] tx_got[$];
  logic [7:0] bus_regs [256] = '{default: 8'h00};
  int wr_cnt = 0, rd_cnt = 0, adj_viol = 0, both_viol = 0, full_viol = 0;
  logic [7:0] last_wr_addr = 8'h00, last_wr_data = 8'h00, last_rd_addr = 8'h00;
  logic prev_pop = 1'b0;

  // RX FIFO, first-word-fall-through; contents are rx_src[rx_rd_ptr..]
  always @(clock) begin : rx_fifo_model
    logic pop;
    if (clock) begin
      pop = rx_fifo_read_en;
      #1;
      if (pop && rx_rd_ptr < rx_src.size()) rx_rd_ptr++;
    end
    rx_fifo_empty    = (rx_rd_ptr >= rx_src.size());
    rx_fifo_data_out = rx_fifo_empty ? 8'h00 : rx_src[rx_rd_ptr];
  end

  // Register space: read data valid only in the cycle after the strobe
  always @(posedge clock) begin : reg_bus_model
    logic r;
    logic [7:0] a;
    if (reg_wr_en) begin
      wr_cnt++;
      last_wr_addr = reg_addr;
      last_wr_data = reg_wr_data;
      bus_regs[reg_addr] = reg_wr_data;
    end
    if (reg_wr_en && reg_rd_en) both_viol++;
    r = reg_rd_en;
    a = reg_addr;
    if (r) begin
      rd_cnt++;
      last_rd_addr = a;
    end
    #1 reg_rd_data = r ? bus_regs[a] : 8'($urandom);
  end

  always @(posedge clock) begin : tx_and_pace_monitor
    if (tx_fifo_write_en) begin
      if (tx_fifo_full) full_viol++;
      else tx_got.push_back(tx_fifo_data_in);
    end
    if (rx_fifo_read_en && prev_pop) adj_viol++;
    prev_pop = rx_fifo_read_en;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] ref_regs [256] = '{default: 8'h00};
  int exp_wr_tot = 0, exp_rd_tot = 0;
  int tx_ptr = 0;
  int tests = 0, fails = 0;

  function automatic bit is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    int v;
    if (c <= 8'h39) v = c - 8'h30;
    else if (c <= 8'h46) v = c - 8'h41 + 10;
    else v = c - 8'h61 + 10;
    return 4'(v);
  endfunction

  function automatic logic [7:0] hex_up(input int n);
    return (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
  endfunction

  // Whole-line semantics: exact-length well-formed W/R lines act, anything else earns E.
  function automatic void model_line(input bq_t ln);
    bit all_hex = 1'b1;
    bit is_w, is_r;
    logic [7:0] a, d, v;
    for (int i = 1; i < ln.size(); i++) if (!is_hex(ln[i])) all_hex = 1'b0;
    is_w = (ln[0] == 8'h57 || ln[0] == 8'h77);
    is_r = (ln[0] == 8'h52 || ln[0] == 8'h72);
    if (is_w && ln.size() == 5 && all_hex) begin
      a = {hex_val(ln[1]), hex_val(ln[2])};
      d = {hex_val(ln[3]), hex_val(ln[4])};
      ref_regs[a] = d;
      exp_wr_tot++;
      exp_q.push_back(8'h4B); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end else if (is_r && ln.size() == 3 && all_hex) begin
      a = {hex_val(ln[1]), hex_val(ln[2])};
      v = ref_regs[a];
      exp_rd_tot++;
      exp_q.push_back(hex_up(int'(v) / 16)); exp_q.push_back(hex_up(int'(v) % 16));
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end else begin
      exp_q.push_back(8'h45); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [7:0] rand_hex(input logic [3:0] n);
    if (n >= 4'd10 && $urandom_range(0, 1) == 1) return 8'h57 + {4'h0, n};
    return hex_up(int'(n));
  endfunction

  function automatic bq_t rand_line();
    bq_t q;
    int kind;
    logic [7:0] a, d, g;
    kind = $urandom_range(0, 3);
    a = 8'($urandom);
    d = 8'($urandom);
    if (kind == 1 || (kind >= 2 && $urandom_range(0, 1) == 1)) begin
      q.push_back($urandom_range(0, 1) ? 8'h52 : 8'h72);
      q.push_back(rand_hex(a[7:4])); q.push_back(rand_hex(a[3:0]));
    end else begin
      q.push_back($urandom_range(0, 1) ? 8'h57 : 8'h77);
      q.push_back(rand_hex(a[7:4])); q.push_back(rand_hex(a[3:0]));
      q.push_back(rand_hex(d[7:4])); q.push_back(rand_hex(d[3:0]));
    end
    if (kind == 2) begin
      int cut = $urandom_range(1, q.size() - 1);
      while (q.size() > cut) void'(q.pop_back());
    end else if (kind == 3) begin
      do g = 8'($urandom_range(0, 255)); while (g == 8'h0D || g == 8'h0A);
      q[$urandom_range(0, q.size() - 1)] = g;
    end
    return q;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic queue_line(input bq_t ln);
    model_line(ln);
    foreach (ln[i]) rx_src.push_back(ln[i]);
    rx_src.push_back(8'h0D);
  endtask

  task automatic drain(input bit bp);
    int n;
    bit done;
    logic [7:0] e;
    n = exp_q.size();
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clock);
      if (tx_got.size() >= tx_ptr + n && rx_rd_ptr == rx_src.size() && !busy) done = 1'b1;
      else if (bp) tx_fifo_full = ($urandom_range(0, 2) == 0);
    end
    tx_fifo_full = 1'b0;
    check("reply_done", 32'(done), 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tx_byte", (tx_ptr < tx_got.size()) ? 32'(tx_got[tx_ptr]) : 32'h100, 32'(e));
      tx_ptr++;
    end
    check("wr_strobes", 32'(wr_cnt), 32'(exp_wr_tot));
    check("rd_strobes", 32'(rd_cnt), 32'(exp_rd_tot));
  endtask

  task automatic run_line(input bq_t ln, input bit bp);
    queue_line(ln);
    drain(bp);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_rx_read_en"}, 32'(rx_fifo_read_en), 0);
    check({pfx, "_tx_write_en"}, 32'(tx_fifo_write_en), 0);
    check({pfx, "_tx_data"}, 32'(tx_fifo_data_in), 0);
    check({pfx, "_reg_addr"}, 32'(reg_addr), 0);
    check({pfx, "_reg_wr_data"}, 32'(reg_wr_data), 0);
    check({pfx, "_reg_wr_en"}, 32'(reg_wr_en), 0);
    check({pfx, "_reg_rd_en"}, 32'(reg_rd_en), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : stimulus
    int p0, t0;
    bit busy_seen, reached;
    logic [7:0] e;

    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // write then read back
    run_line(to_q("W3CA5"), 1'b0);
    check("wr_addr", 32'(last_wr_addr), 32'h3C);
    check("wr_data", 32'(last_wr_data), 32'hA5);
    run_line(to_q("r3c"), 1'b0);
    check("rd_addr", 32'(last_rd_addr), 32'h3C);
    check("hold_addr", 32'(reg_addr), 32'h3C);
    check("hold_wr_data", 32'(reg_wr_data), 32'hA5);

    // malformed lines
    run_line(to_q("W3G12"), 1'b0);
    run_line(to_q("R1"), 1'b0);
    run_line(to_q("X"), 1'b0);

    // blank lines
    t0 = tx_got.size();
    busy_seen = 1'b0;
    rx_src.push_back(8'h0D); rx_src.push_back(8'h0A);
    rx_src.push_back(8'h0D); rx_src.push_back(8'h0A);
    repeat (20) begin
      @(negedge clock);
      busy_seen |= busy;
    end
    check("blank_busy", 32'(busy_seen), 0);
    check("blank_tx", 32'(tx_got.size() - t0), 0);
    check("blank_popped", 32'(rx_rd_ptr), 32'(rx_src.size()));
    check("blank_wr", 32'(wr_cnt), 32'(exp_wr_tot));
    check("blank_rd", 32'(rd_cnt), 32'(exp_rd_tot));

    // back-pressure during a read reply, with a second line waiting in RX
    tx_fifo_full = 1'b1;
    p0 = rx_rd_ptr;
    t0 = tx_got.size();
    queue_line(to_q("R3C"));
    queue_line(to_q("W0102"));
    repeat (40) @(negedge clock);
    check("bp_no_push", 32'(tx_got.size() - t0), 0);
    check("bp_no_pop", 32'(rx_rd_ptr - p0), 4);
    check("bp_busy", 32'(busy), 1);
    tx_fifo_full = 1'b0;
    drain(1'b0);

    // pop pacing with two lines preloaded
    queue_line(to_q("W0011"));
    queue_line(to_q("R00"));
    drain(1'b0);
    check("pop_gap", 32'(adj_viol), 0);

    // reset in the middle of a read reply
    queue_line(to_q("R3C"));
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      @(negedge clock);
      if (tx_got.size() >= tx_ptr + 2) reached = 1'b1;
    end
    check("rst_reached", 32'(reached), 1);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      check("rst_tx_byte", (tx_ptr < tx_got.size()) ? 32'(tx_got[tx_ptr]) : 32'h100, 32'(e));
      tx_ptr++;
    end
    exp_q.delete();
    repeat (3) @(negedge clock);
    check("rst_no_more_tx", 32'(tx_got.size() - tx_ptr), 0);
    reset_n = 1'b1;
    @(negedge clock);
    run_line(to_q("R00"), 1'b0);

    // random lines with random back-pressure
    for (int k = 0; k < 40; k++) run_line(rand_line(), ($urandom_range(0, 1) == 1));

    check("final_pop_gap", 32'(adj_viol), 0);
    check("final_wr_rd_overlap", 32'(both_viol), 0);
    check("final_push_when_full", 32'(full_viol), 0);
    check("final_extra_tx", 32'(tx_got.size() - tx_ptr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART block: pops received bytes from its RX FIFO and pushes reply bytes into its TX FIFO.
- Decodes a fixed-format ASCII hex command line into single-cycle register-bus reads and writes.
- Produces a fixed ASCII reply for every terminated command line.
- Gives a PC terminal register-level access to the rest of the design.

Parameters:
ACK_CHAR, 8'h4B, reply byte sent for a successful write ('K')
ERR_CHAR, 8'h45, reply byte sent for a malformed line ('E')

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
rx_fifo_empty  in  1  UART RX FIFO empty flag
rx_fifo_data_out  in  8  RX FIFO head byte, first-word-fall-through, valid while rx_fifo_empty=0
rx_fifo_read_en  out  1  one-cycle pop strobe to RX FIFO
tx_fifo_full  in  1  UART TX FIFO full flag (tie 0 if not exported)
tx_fifo_data_in  out  8  reply byte
tx_fifo_write_en  out  1  one-cycle push strobe to TX FIFO
reg_addr  out  8  register bus address
reg_wr_data  out  8  register write data
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_rd_data  in  8  read data, valid exactly 1 cycle after reg_rd_en
busy  out  1  high from command letter until last reply byte is pushed

Behaviour:
- Reset: every output = 0, state = IDLE, hex accumulators = 0; reset_n low mid-reply aborts the reply; bytes already pushed stay in the TX FIFO.
- Byte fetch: when rx_fifo_empty=0 and the parser waits for input, latch rx_fifo_data_out and pulse rx_fifo_read_en for 1 cycle. The next cycle is a mandatory gap with no pop, so the FIFO flags can update; max rate is one byte per 2 cycles. The byte is decoded in the cycle after the pop.
- Grammar:
  - Write line: 'W'|'w', 2 hex digits address, 2 hex digits data, CR (8'h0D).
  - Read line: 'R'|'r', 2 hex digits address, CR.
  - Hex digits are 0-9, A-F, a-f, most significant nibble first. No spaces.
- States: IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WAIT_CR, EXEC_WR, EXEC_RD, RD_WAIT, RESP, DISCARD.
- IDLE:
  - LF (8'h0A) and CR are dropped, with no reply.
  - W or R: busy=1 and go to ADDR_HI. The command type is latched.
  - Any other byte goes to DISCARD.
- ADDR_HI / ADDR_LO / DATA_HI / DATA_LO:
  - Non-hex byte: go to DISCARD.
  - CR received early: queue the error reply immediately and go to RESP.
- After ADDR_LO, a write goes to DATA_HI and a read goes to WAIT_CR.
- WAIT_CR:
  - CR: write goes to EXEC_WR, read goes to EXEC_RD.
  - Any other byte goes to DISCARD.
- DISCARD: pop and drop bytes until CR, then queue the error reply {ERR_CHAR, CR, LF}.
- EXEC_WR:
  - Drive reg_addr and reg_wr_data, pulse reg_wr_en for 1 cycle.
  - Queue {ACK_CHAR, CR, LF}.
- EXEC_RD: drive reg_addr, pulse reg_rd_en for 1 cycle, then go to RD_WAIT.
- RD_WAIT: capture reg_rd_data, then queue {hex_hi, hex_lo, CR, LF}. Hex output is uppercase ASCII ('0'-'9', 'A'-'F').
- RESP:
  - Reply queue is at most 4 bytes.
  - Push one byte per cycle while tx_fifo_full=0; tx_fifo_write_en is low whenever tx_fifo_full=1. A byte is never dropped.
  - After the last byte, busy=0 and go to IDLE.
  - No RX pops occur while in EXEC_WR, EXEC_RD, RD_WAIT or RESP.
- reg_addr and reg_wr_data hold their last value between commands.
- reg_wr_en and reg_rd_en are never high in the same cycle.

Test Plan:
- Write then read: RX "W3CA5\r" -> reg_wr_en 1 cycle with addr 8'h3C, data 8'hA5; TX 8'h4B,8'h0D,8'h0A. Then RX "r3c\r" with reg_rd_data=8'hA5 -> reg_rd_en 1 cycle, addr 8'h3C; TX "A5\r\n" (8'h41,8'h35,8'h0D,8'h0A).
- Malformed lines: RX "W3G12\r" -> no reg strobe; TX "E\r\n". RX "R1\r" (early CR) -> TX "E\r\n". RX "X\r" -> TX "E\r\n".
- Blank lines: RX "\r\n\r\n" -> no strobes, no TX writes, busy stays 0.
- Back-pressure: tx_fifo_full=1 during a read reply -> tx_fifo_write_en stays 0. Release -> all 4 bytes pushed in order with none lost; RX FIFO not popped until the reply ends.
- Pop pacing: RX FIFO preloaded with "W0011\rR00\r" -> rx_fifo_read_en pulses never in adjacent cycles; both replies appear in order ("K\r\n" then "11\r\n").
- Reset: assert reset_n=0 after the 2nd reply byte of a read -> all outputs 0 asynchronously. After release, "R00\r" is handled normally.
